fg_packet_gen: RTL and testbench
================================

FG_PACKET_GEN -- requirements
Module: fg_packet_gen

Interface
REQ-001 Parameter DEST_WIDTH, default 8: width of burst/packet destination field.
REQ-002 Parameter DATA_WIDTH, default 64: output stream data width in bits, multiple of 8.
REQ-003 Parameter KEEP_WIDTH, default DATA_WIDTH/8: output byte-enable width.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 input_bd_valid  in  1  burst descriptor valid.
REQ-007 input_bd_ready  out  1  burst descriptor accepted when valid&ready.
REQ-008 input_bd_dest  in  DEST_WIDTH  burst destination.
REQ-009 input_bd_burst_len  in  32  burst length in bytes.
REQ-010 output_axis_tdata  out  DATA_WIDTH  payload; byte i of a beat = low 8 bits of that byte's offset within its packet.
REQ-011 output_axis_tkeep  out  KEEP_WIDTH  byte enables, contiguous from bit 0.
REQ-012 output_axis_tvalid  out  1  beat valid.
REQ-013 output_axis_tready  in  1  sink ready.
REQ-014 output_axis_tlast  out  1  last beat of packet.
REQ-015 output_axis_tdest  out  DEST_WIDTH  packet destination.
REQ-016 payload_mtu  in  16  max packet payload bytes; sampled at descriptor acceptance; 0 = unlimited.
REQ-017 busy  out  1  high while a burst is in progress.
REQ-018 burst_count  out  32  number of bursts fully transmitted, wraps at 2^32.

Function
REQ-019 States: IDLE, SEND; input_bd_ready SHALL be 1 only in IDLE.
REQ-020 IDLE, valid&ready, burst_len>0: latch dest, burst_len, effective MTU (0 -> 2^32-1); go SEND; first beat valid on the next cycle.
REQ-021 IDLE, valid&ready, burst_len=0: descriptor consumed, no beats, burst_count increments, stay IDLE.
REQ-022 Burst split into packets of min(remaining, MTU) bytes, in order, no gap cycles between packets when tready=1.
REQ-023 Each packet: ceil(len/KEEP_WIDTH) beats; non-last beats tkeep all ones; last beat tkeep low (len mod KEEP_WIDTH) bits set, all ones if remainder 0; tlast=1 only on last beat.
REQ-024 Beat transfers on tvalid&tready; while tvalid&!tready, tdata/tkeep/tlast/tdest SHALL hold stable.
REQ-025 tdest SHALL equal latched dest for every beat of the burst.
REQ-026 On transfer of last beat of last packet: burst_count+1, return to IDLE same edge; input_bd_ready=1 next cycle (1-cycle bubble between bursts).
REQ-027 busy = (state == SEND); tvalid SHALL be 0 in IDLE.
REQ-028 Remaining-byte counters 32-bit, no overflow for burst_len up to 2^32-1.
REQ-029 payload_mtu changes during SEND SHALL have no effect on the current burst.

Reset
REQ-030 While rst=0: state IDLE, input_bd_ready=0, tvalid=0, tlast=0, tdata=0, tkeep=0, tdest=0, busy=0, burst_count=0.
REQ-031 input_bd_ready SHALL rise on the first clock edge after rst deasserts.
REQ-032 Reset mid-burst SHALL abort immediately; no further beats of the aborted burst after release.

Verification (DATA_WIDTH=64)
REQ-033 burst_len=20, dest=0x5A, mtu=0, tready=1 -> 3 beats, tkeep FF/FF/0F, tlast beat 3 only, tdest 0x5A, bytes 0x00..0x13, burst_count=1.
REQ-034 burst_len=20, mtu=8 -> 3 single-beat packets, tkeep FF/FF/0F, tlast on each, byte 0 of each packet = 0x00.
REQ-035 burst_len=0 -> one-cycle handshake, no tvalid, burst_count+1, busy stays 0.
REQ-036 burst_len=64, tready toggling 1/0 every cycle -> 8 beats, outputs stable during stalls, no lost or duplicated beats.
REQ-037 rst low during beat 2 of a 40-byte burst -> all outputs at reset values asynchronously; after release, new 8-byte descriptor yields one beat tkeep FF, tlast 1.
REQ-038 Two back-to-back descriptors (16 B, 8 B) -> 2 beats, 1 bubble cycle, 1 beat; burst_count=2.

Source files
------------

// File: rtl/fg_packet_gen.sv
// fg_packet_gen: turns burst descriptors into an AXI-Stream packet train.
// Each burst is cut into packets of at most the MTU sampled at acceptance;
// every payload byte carries the low 8 bits of its offset inside its packet.
module fg_packet_gen #(
  parameter int DEST_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_bd_valid,
  output logic                  input_bd_ready,
  input  logic [DEST_WIDTH-1:0] input_bd_dest,
  input  logic [31:0]           input_bd_burst_len,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic [DEST_WIDTH-1:0] output_axis_tdest,
  input  logic [15:0]           payload_mtu,
  output logic                  busy,
  output logic [31:0]           burst_count
);

  localparam logic [31:0] KW32 = 32'(KEEP_WIDTH);
  localparam logic [7:0]  KW8  = 8'(KEEP_WIDTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_ready_en;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [31:0]           r_mtu;
  logic [31:0]           r_pkt_rem;    // bytes left in current packet, current beat included
  logic [31:0]           r_burst_rem;  // bytes left in burst after current packet
  logic [7:0]            r_off;        // packet offset of byte 0 of current beat
  logic [31:0]           r_burst_count;

  logic                  w_bd_fire;
  logic                  w_beat_fire;
  logic                  w_beat_last;
  logic                  w_burst_done;
  logic                  w_zero_len;
  logic [31:0]           w_mtu_eff;
  logic [31:0]           w_first_len;
  logic [31:0]           w_next_len;
  logic [KEEP_WIDTH-1:0] w_keep;
  logic [DATA_WIDTH-1:0] w_data;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  assign w_bd_fire    = input_bd_valid && input_bd_ready;
  assign w_zero_len   = (input_bd_burst_len == 32'd0);
  assign w_beat_fire  = (r_state == S_SEND) && output_axis_tready;
  assign w_beat_last  = (r_pkt_rem <= KW32);
  assign w_burst_done = w_beat_fire && w_beat_last && (r_burst_rem == 32'd0);
  assign w_mtu_eff    = (payload_mtu == 16'd0) ? 32'hFFFF_FFFF : {16'd0, payload_mtu};
  assign w_first_len  = min32(input_bd_burst_len, w_mtu_eff);
  assign w_next_len   = min32(r_burst_rem, r_mtu);

  // Beat contents follow from remaining packet bytes and packet offset alone
  always_comb begin
    w_keep = '0;
    w_data = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      w_keep[i]         = (r_pkt_rem > 32'(i));
      w_data[8*i +: 8]  = r_off + 8'(i);
    end
  end

  // State register; descriptor acceptance is held off until one edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ready_en <= 1'b1;
    end
  end

  // Next-state: zero-length descriptors complete without leaving IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_bd_fire && !w_zero_len) w_state_next = S_SEND;
      S_SEND: if (w_burst_done)             w_state_next = S_IDLE;
      default:                              w_state_next = S_IDLE;
    endcase
  end

  // Outputs are forced to zero outside SEND so reset and idle look identical
  always_comb begin
    input_bd_ready     = (r_state == S_IDLE) && r_ready_en;
    busy               = (r_state == S_SEND);
    output_axis_tvalid = 1'b0;
    output_axis_tlast  = 1'b0;
    output_axis_tkeep  = '0;
    output_axis_tdata  = '0;
    output_axis_tdest  = '0;
    if (r_state == S_SEND) begin
      output_axis_tvalid = 1'b1;
      output_axis_tlast  = w_beat_last;
      output_axis_tkeep  = w_keep;
      output_axis_tdata  = w_data;
      output_axis_tdest  = r_dest;
    end
    burst_count = r_burst_count;
  end

  // Packet/beat bookkeeping: load first packet on accept, advance on each transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dest      <= '0;
      r_mtu       <= '0;
      r_pkt_rem   <= '0;
      r_burst_rem <= '0;
      r_off       <= '0;
    end else if (w_bd_fire) begin
      r_dest      <= input_bd_dest;
      r_mtu       <= w_mtu_eff;
      r_pkt_rem   <= w_first_len;
      r_burst_rem <= input_bd_burst_len - w_first_len;
      r_off       <= '0;
    end else if (w_beat_fire) begin
      if (w_beat_last) begin
        r_pkt_rem   <= w_next_len;
        r_burst_rem <= r_burst_rem - w_next_len;
        r_off       <= '0;
      end else begin
        r_pkt_rem   <= r_pkt_rem - KW32;
        r_off       <= r_off + KW8;
      end
    end
  end

  // Completed-burst counter, including bursts of zero length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_burst_count <= '0;
    end else if ((w_bd_fire && w_zero_len) || w_burst_done) begin
      r_burst_count <= r_burst_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fg_packet_gen.sv
// Directed bench for fg_packet_gen with 64-bit data and 8-bit destination.
module tb_fg_packet_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        input_bd_valid = 1'b0;
  logic        input_bd_ready;
  logic [7:0]  input_bd_dest = 8'd0;
  logic [31:0] input_bd_burst_len = 32'd0;
  logic [63:0] output_axis_tdata;
  logic [7:0]  output_axis_tkeep;
  logic        output_axis_tvalid;
  logic        output_axis_tready = 1'b1;
  logic        output_axis_tlast;
  logic [7:0]  output_axis_tdest;
  logic [15:0] payload_mtu = 16'd0;
  logic        busy;
  logic [31:0] burst_count;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] bt_data [16];
  logic [7:0]  bt_keep [16];
  logic        bt_last [16];
  logic [7:0]  bt_dest [16];
  int          nb;

  fg_packet_gen #(.DEST_WIDTH(8), .DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_bd_valid     (input_bd_valid),
    .input_bd_ready     (input_bd_ready),
    .input_bd_dest      (input_bd_dest),
    .input_bd_burst_len (input_bd_burst_len),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tkeep  (output_axis_tkeep),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .output_axis_tlast  (output_axis_tlast),
    .output_axis_tdest  (output_axis_tdest),
    .payload_mtu        (payload_mtu),
    .busy               (busy),
    .burst_count        (burst_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; presents a descriptor until it is accepted.
  task automatic send_desc(input logic [31:0] len, input logic [7:0] dest, input logic [15:0] mtu);
    int w = 0;
    while (!input_bd_ready && w < 20) begin
      step();
      w++;
    end
    if (!input_bd_ready) begin
      check("bd_ready_timeout", {63'd0, input_bd_ready}, 64'd1);
      return;
    end
    input_bd_valid     = 1'b1;
    input_bd_burst_len = len;
    input_bd_dest      = dest;
    payload_mtu        = mtu;
    step();
    input_bd_valid     = 1'b0;
  endtask

  // Records transferred beats until the burst ends; checks hold during stalls.
  task automatic collect(input bit toggle, input int budget);
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    logic [7:0]  sdst;
    bit          stalled;
    stalled = 1'b0;
    sd = '0; sk = '0; sl = 1'b0; sdst = '0;
    nb = 0;
    for (int c = 0; c < budget; c++) begin
      if (stalled) begin
        check("stall_tvalid", {63'd0, output_axis_tvalid}, 64'd1);
        check("stall_tdata", output_axis_tdata, sd);
        check("stall_tkeep", {56'd0, output_axis_tkeep}, {56'd0, sk});
        check("stall_tlast", {63'd0, output_axis_tlast}, {63'd0, sl});
        check("stall_tdest", {56'd0, output_axis_tdest}, {56'd0, sdst});
      end
      if (!busy) break;
      output_axis_tready = toggle ? ((c % 2) == 1) : 1'b1;
      if (output_axis_tvalid && output_axis_tready && nb < 16) begin
        bt_data[nb] = output_axis_tdata;
        bt_keep[nb] = output_axis_tkeep;
        bt_last[nb] = output_axis_tlast;
        bt_dest[nb] = output_axis_tdest;
        nb++;
      end
      stalled = output_axis_tvalid && !output_axis_tready;
      sd = output_axis_tdata; sk = output_axis_tkeep;
      sl = output_axis_tlast; sdst = output_axis_tdest;
      step();
    end
    output_axis_tready = 1'b1;
    check("burst_end_busy", {63'd0, busy}, 64'd0);
    check("idle_tvalid", {63'd0, output_axis_tvalid}, 64'd0);
  endtask

  initial begin
    logic tv [5];
    logic rd [5];
    logic tl [5];
    logic [7:0] td [5];

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, input_bd_ready}, 64'd0);
    check("rst_tvalid", {63'd0, output_axis_tvalid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_count", {32'd0, burst_count}, 64'd0);
    check("rst_tdata", output_axis_tdata, 64'd0);
    check("rst_tkeep", {56'd0, output_axis_tkeep}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_ready_before_edge", {63'd0, input_bd_ready}, 64'd0);
    step();
    check("release_ready_after_edge", {63'd0, input_bd_ready}, 64'd1);

    // ---------------- 20 bytes, unlimited MTU ----------------
    send_desc(32'd20, 8'h5A, 16'd0);
    check("b1_first_beat_tvalid", {63'd0, output_axis_tvalid}, 64'd1);
    check("b1_busy", {63'd0, busy}, 64'd1);
    check("b1_ready_in_send", {63'd0, input_bd_ready}, 64'd0);
    collect(1'b0, 20);
    check("b1_nbeats", 64'(nb), 64'd3);
    check("b1_keep0", {56'd0, bt_keep[0]}, 64'hFF);
    check("b1_keep1", {56'd0, bt_keep[1]}, 64'hFF);
    check("b1_keep2", {56'd0, bt_keep[2]}, 64'h0F);
    check("b1_last", {61'd0, bt_last[0], bt_last[1], bt_last[2]}, 64'b001);
    check("b1_data0", bt_data[0], 64'h0706050403020100);
    check("b1_data1", bt_data[1], 64'h0F0E0D0C0B0A0908);
    check("b1_data2", bt_data[2], 64'h1716151413121110);
    for (int i = 0; i < 3; i++) check($sformatf("b1_dest%0d", i), {56'd0, bt_dest[i]}, 64'h5A);
    check("b1_count", {32'd0, burst_count}, 64'd1);
    check("b1_ready_back", {63'd0, input_bd_ready}, 64'd1);

    // ---------------- 20 bytes, MTU 8 (MTU changed mid-burst) ----------------
    send_desc(32'd20, 8'hC3, 16'd8);
    payload_mtu = 16'd0;
    collect(1'b0, 20);
    check("b2_nbeats", 64'(nb), 64'd3);
    check("b2_keep0", {56'd0, bt_keep[0]}, 64'hFF);
    check("b2_keep1", {56'd0, bt_keep[1]}, 64'hFF);
    check("b2_keep2", {56'd0, bt_keep[2]}, 64'h0F);
    check("b2_last", {61'd0, bt_last[0], bt_last[1], bt_last[2]}, 64'b111);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2_data%0d", i), bt_data[i], 64'h0706050403020100);
      check($sformatf("b2_dest%0d", i), {56'd0, bt_dest[i]}, 64'hC3);
    end
    check("b2_count", {32'd0, burst_count}, 64'd2);

    // ---------------- zero-length burst ----------------
    send_desc(32'd0, 8'h01, 16'd0);
    check("b3_busy", {63'd0, busy}, 64'd0);
    check("b3_tvalid", {63'd0, output_axis_tvalid}, 64'd0);
    check("b3_count", {32'd0, burst_count}, 64'd3);
    check("b3_ready", {63'd0, input_bd_ready}, 64'd1);
    step();
    check("b3_tvalid_later", {63'd0, output_axis_tvalid}, 64'd0);

    // ---------------- 64 bytes with tready toggling ----------------
    send_desc(32'd64, 8'h77, 16'd0);
    collect(1'b1, 40);
    check("b4_nbeats", 64'(nb), 64'd8);
    for (int k = 0; k < 8; k++) begin
      logic [63:0] exp_d;
      for (int b = 0; b < 8; b++) exp_d[8*b +: 8] = 8'(8*k + b);
      check($sformatf("b4_data%0d", k), bt_data[k], exp_d);
      check($sformatf("b4_keep%0d", k), {56'd0, bt_keep[k]}, 64'hFF);
      check($sformatf("b4_last%0d", k), {63'd0, bt_last[k]}, (k == 7) ? 64'd1 : 64'd0);
    end
    check("b4_count", {32'd0, burst_count}, 64'd4);

    // ---------------- reset during beat 2 of a 40-byte burst ----------------
    send_desc(32'd40, 8'h33, 16'd0);
    step();
    check("b5_beat2_present", {63'd0, output_axis_tvalid}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("b5_async_ready", {63'd0, input_bd_ready}, 64'd0);
    check("b5_async_tvalid", {63'd0, output_axis_tvalid}, 64'd0);
    check("b5_async_tlast", {63'd0, output_axis_tlast}, 64'd0);
    check("b5_async_tdata", output_axis_tdata, 64'd0);
    check("b5_async_tkeep", {56'd0, output_axis_tkeep}, 64'd0);
    check("b5_async_tdest", {56'd0, output_axis_tdest}, 64'd0);
    check("b5_async_busy", {63'd0, busy}, 64'd0);
    check("b5_async_count", {32'd0, burst_count}, 64'd0);
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("b5_release_ready", {63'd0, input_bd_ready}, 64'd0);
    step();
    check("b5_no_resume", {63'd0, output_axis_tvalid}, 64'd0);
    check("b5_ready_up", {63'd0, input_bd_ready}, 64'd1);
    send_desc(32'd8, 8'h44, 16'd0);
    collect(1'b0, 20);
    check("b5_nbeats", 64'(nb), 64'd1);
    check("b5_keep", {56'd0, bt_keep[0]}, 64'hFF);
    check("b5_last", {63'd0, bt_last[0]}, 64'd1);
    check("b5_data", bt_data[0], 64'h0706050403020100);
    check("b5_count", {32'd0, burst_count}, 64'd1);

    // ---------------- back-to-back 16 B then 8 B ----------------
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    send_desc(32'd16, 8'h11, 16'd0);
    input_bd_valid     = 1'b1;
    input_bd_burst_len = 32'd8;
    input_bd_dest      = 8'h22;
    for (int c = 0; c < 5; c++) begin
      tv[c] = output_axis_tvalid;
      rd[c] = input_bd_ready;
      tl[c] = output_axis_tlast;
      td[c] = output_axis_tdest;
      step();
      if (rd[c]) input_bd_valid = 1'b0;
    end
    input_bd_valid = 1'b0;
    check("b6_tvalid_seq", {59'd0, tv[0], tv[1], tv[2], tv[3], tv[4]}, 64'b11010);
    check("b6_ready_seq", {59'd0, rd[0], rd[1], rd[2], rd[3], rd[4]}, 64'b00101);
    check("b6_tlast_seq", {59'd0, tl[0], tl[1], tl[2], tl[3], tl[4]}, 64'b01010);
    check("b6_dest_first", {56'd0, td[0]}, 64'h11);
    check("b6_dest_second", {56'd0, td[3]}, 64'h22);
    check("b6_count", {32'd0, burst_count}, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
